instr_fetch: RTL and testbench

- Fetch stage of the single-issue RISC-V core; sits directly upstream of the instruction RAM (async-read, word-addressed, 32-bit data) and feeds the decode stage.
- Owns the program counter and drives the RAM word address; registers the returned instruction plus its PC into an IF/ID output register with a valid/ready handshake.
- Accepts redirects (jump/branch/trap) from execute and halts with a fault flag on a misaligned target.

---
 rtl/instr_fetch_if.sv | 54 +++++
 rtl/instr_fetch.sv | 125 ++++++++++++
 tb/tb_instr_fetch.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: instruction RAM port, execute redirect, IF/ID handshake and status.
`timescale 1ns/1ps

interface instr_fetch_if #(
  parameter int unsigned ADDR_W = 9
);
  localparam int unsigned XLEN = 32;

  // instruction RAM (async read, word addressed)
  logic [ADDR_W-1:0] imem_addr_o;
  logic [XLEN-1:0]   imem_rd_i;

  // redirect from execute
  logic              redirect_i;
  logic [XLEN-1:0]   redirect_pc_i;

  // IF/ID output register and handshake
  logic [XLEN-1:0]   instr_o;
  logic [XLEN-1:0]   pc_o;
  logic              valid_o;
  logic              ready_i;

  // status
  logic              fault_o;
  logic [XLEN-1:0]   fetch_cnt_o;

  // fetch unit side
  modport master (
    output imem_addr_o,
    input  imem_rd_i,
    input  redirect_i,
    input  redirect_pc_i,
    output instr_o,
    output pc_o,
    output valid_o,
    input  ready_i,
    output fault_o,
    output fetch_cnt_o
  );

  // environment side: RAM, execute and decode
  modport slave (
    input  imem_addr_o,
    output imem_rd_i,
    output redirect_i,
    output redirect_pc_i,
    input  instr_o,
    input  pc_o,
    input  valid_o,
    output ready_i,
    input  fault_o,
    input  fetch_cnt_o
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, reads the async instruction RAM and
// presents (instr, pc) to decode through a valid/ready output register.
// Redirects from execute flush the output register; a misaligned target halts
// the stage with a sticky fault until reset.
`timescale 1ns/1ps

module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned ADDR_W   = 9,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic          clk_i,
  input  logic          rst_i,
  instr_fetch_if.master bus
);

  localparam int unsigned XLEN    = 32;
  localparam int unsigned ADDR_HI = ADDR_W + 1;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] pc_out_q, pc_out_d;
  logic            valid_q, valid_d;
  logic            fault_q, fault_d;
  logic [XLEN-1:0] cnt_q, cnt_d;

  logic            load_c;
  logic            accept_c;
  logic            misaligned_c;

  // Output register may take a new entry when empty or being drained this cycle.
  assign load_c       = !valid_q || bus.ready_i;
  assign accept_c     = valid_q && bus.ready_i;
  assign misaligned_c = (bus.redirect_pc_i[1:0] != 2'b00);

  // RAM word address straight from the PC; upper PC bits wrap the RAM.
  assign bus.imem_addr_o = pc_q[ADDR_HI:2];

  assign bus.instr_o     = instr_q;
  assign bus.pc_o        = pc_out_q;
  assign bus.valid_o     = valid_q;
  assign bus.fault_o     = fault_q;
  assign bus.fetch_cnt_o = cnt_q;

  // State and datapath registers; reset overrides any pending stall or redirect.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q  <= BOOT;
      pc_q     <= RESET_PC;
      instr_q  <= NOP;
      pc_out_q <= '0;
      valid_q  <= 1'b0;
      fault_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pc_out_q <= pc_out_d;
      valid_q  <= valid_d;
      fault_q  <= fault_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next-state and datapath update: redirect beats load, load beats stall.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    pc_out_d = pc_out_q;
    valid_d  = valid_q;
    fault_d  = fault_q;
    cnt_d    = cnt_q;

    unique case (state_q)
      BOOT, FETCH: begin
        // A handshake in the same cycle as a flush was still consumed by decode.
        if (accept_c) begin
          cnt_d = cnt_q + XLEN'(1);
        end

        if (bus.redirect_i) begin
          if (misaligned_c) begin
            // Park with the faulting address visible; the PC is left untouched.
            state_d  = HALT;
            fault_d  = 1'b1;
            valid_d  = 1'b0;
            instr_d  = NOP;
            pc_out_d = bus.redirect_pc_i;
          end else begin
            state_d  = FETCH;
            pc_d     = bus.redirect_pc_i;
            valid_d  = 1'b0;
            instr_d  = NOP;
          end
        end else if (state_q == BOOT) begin
          // One idle cycle after reset so the RAM sees RESET_PC before the first capture.
          state_d = FETCH;
        end else if (load_c) begin
          instr_d  = bus.imem_rd_i;
          pc_out_d = pc_q;
          valid_d  = 1'b1;
          pc_d     = pc_q + XLEN'(4);
        end
      end

      HALT: begin
        // Frozen until reset; redirects are ignored and nothing is accepted.
      end

      default: begin
        state_d = BOOT;
      end
    endcase
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus randomized
// ready/redirect/reset traffic compared against a transaction-level model.
`timescale 1ns/1ps

module tb_instr_fetch;

  localparam int unsigned ADDR_W = 9;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst;
  logic ready;
  logic redirect;
  logic [31:0] rpc;

  int checks   = 0;
  int failures = 0;

  // Reference model: the pending fetch address, the visible entry and status.
  logic [31:0] m_npc;
  logic        m_boot;
  logic        m_halt;
  logic        m_valid;
  logic [31:0] m_instr;
  logic [31:0] m_pc;
  logic        m_fault;
  logic [31:0] m_cnt;

  instr_fetch_if #(.ADDR_W(ADDR_W)) bus ();

  instr_fetch #(
    .RESET_PC (RST_PC),
    .ADDR_W   (ADDR_W),
    .NOP      (NOP)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Instruction RAM: word k holds A000_0000 | k.
  assign bus.imem_rd_i     = 32'hA000_0000 | 32'(bus.imem_addr_o);
  assign bus.ready_i       = ready;
  assign bus.redirect_i    = redirect;
  assign bus.redirect_pc_i = rpc;

  function automatic logic [31:0] ram_word(input logic [31:0] byte_addr);
    logic [ADDR_W-1:0] w;
    w = byte_addr[ADDR_W+1:2];
    return 32'hA000_0000 | 32'(w);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply one clock edge of the fetch rules to the model.
  task automatic model_edge();
    if (!rst) begin
      m_npc   = RST_PC;
      m_boot  = 1'b1;
      m_halt  = 1'b0;
      m_valid = 1'b0;
      m_instr = NOP;
      m_pc    = 32'h0;
      m_fault = 1'b0;
      m_cnt   = 32'h0;
    end else if (!m_halt) begin
      if (m_valid && ready) m_cnt = m_cnt + 32'd1;
      if (redirect) begin
        if (rpc[1:0] != 2'b00) begin
          m_halt  = 1'b1;
          m_fault = 1'b1;
          m_valid = 1'b0;
          m_instr = NOP;
          m_pc    = rpc;
        end else begin
          m_npc   = rpc;
          m_valid = 1'b0;
          m_instr = NOP;
          m_boot  = 1'b0;
        end
      end else if (m_boot) begin
        m_boot = 1'b0;
      end else if (!m_valid || ready) begin
        m_instr = ram_word(m_npc);
        m_pc    = m_npc;
        m_valid = 1'b1;
        m_npc   = m_npc + 32'd4;
      end
    end
  endtask

  task automatic check_model();
    logic [ADDR_W-1:0] exp_addr;
    exp_addr = m_npc[ADDR_W+1:2];
    check("m_valid", 32'(bus.valid_o), 32'(m_valid));
    check("m_instr", bus.instr_o, m_instr);
    check("m_pc",    bus.pc_o, m_pc);
    check("m_fault", 32'(bus.fault_o), 32'(m_fault));
    check("m_cnt",   bus.fetch_cnt_o, m_cnt);
    check("m_addr",  32'(bus.imem_addr_o), 32'(exp_addr));
  endtask

  // One clock: inputs are stable across the edge, outputs sampled 1ns later.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  initial begin
    rst = 1'b0; ready = 1'b0; redirect = 1'b0; rpc = 32'h0;

    // Reset held for two cycles
    step(); step();
    check("rst_valid", 32'(bus.valid_o), 32'h0);
    check("rst_instr", bus.instr_o, NOP);
    check("rst_pc",    bus.pc_o, 32'h0);
    check("rst_fault", 32'(bus.fault_o), 32'h0);
    check("rst_cnt",   bus.fetch_cnt_o, 32'h0);
    check("rst_addr",  32'(bus.imem_addr_o), 32'h0);

    // Free run: first valid two edges after release
    rst = 1'b1; ready = 1'b1;
    step();
    check("boot_valid", 32'(bus.valid_o), 32'h0);
    step();
    check("run0_valid", 32'(bus.valid_o), 32'h1);
    check("run0_pc",    bus.pc_o, 32'h0);
    check("run0_instr", bus.instr_o, 32'hA000_0000);
    step();
    check("run1_pc",    bus.pc_o, 32'h4);
    check("run1_instr", bus.instr_o, 32'hA000_0001);
    step();
    check("run2_pc",    bus.pc_o, 32'h8);
    check("run2_instr", bus.instr_o, 32'hA000_0002);

    // Backpressure holds the entry at pc 8
    ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("stall_pc",    bus.pc_o, 32'h8);
      check("stall_instr", bus.instr_o, 32'hA000_0002);
      check("stall_cnt",   bus.fetch_cnt_o, 32'd2);
    end
    ready = 1'b1;
    step();
    check("unstall_pc",  bus.pc_o, 32'hC);
    check("unstall_cnt", bus.fetch_cnt_o, 32'd3);

    // Redirect to 0x100 while stalled
    ready = 1'b0; redirect = 1'b1; rpc = 32'h100;
    step();
    check("redir_valid", 32'(bus.valid_o), 32'h0);
    check("redir_instr", bus.instr_o, NOP);
    redirect = 1'b0;
    step();
    check("redir_pc",    bus.pc_o, 32'h100);
    check("redir_ins",   bus.instr_o, 32'hA000_0040);
    ready = 1'b1;
    step();
    check("redir_pc1",   bus.pc_o, 32'h104);
    check("redir_ins1",  bus.instr_o, 32'hA000_0041);

    // RAM address wrap past word 511
    redirect = 1'b1; rpc = 32'h7FC;
    step();
    redirect = 1'b0;
    step();
    check("wrap_pc0",   bus.pc_o, 32'h7FC);
    check("wrap_ins0",  bus.instr_o, 32'hA000_01FF);
    check("wrap_addr",  32'(bus.imem_addr_o), 32'h0);
    step();
    check("wrap_pc1",   bus.pc_o, 32'h800);
    check("wrap_ins1",  bus.instr_o, 32'hA000_0000);

    // Randomized ready / redirect / reset traffic
    for (int i = 0; i < 600; i++) begin
      ready    = ($urandom_range(0, 3) != 0);
      redirect = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 1) == 0) rpc = $urandom & 32'h0000_0FFC;
      else                           rpc = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 7) == 0) rpc = 32'hFFFF_FFF8;
      if ($urandom_range(0, 24) == 0) rpc[1:0] = 2'(1 + $urandom_range(0, 2));
      rst = ($urandom_range(0, 39) != 0);
      step();
    end
    redirect = 1'b0; rst = 1'b0;
    step();
    rst = 1'b1; ready = 1'b1;
    step(); step(); step();

    // Misaligned redirect halts; later redirects ignored; reset recovers
    redirect = 1'b1; rpc = 32'h202;
    step();
    check("mis_fault", 32'(bus.fault_o), 32'h1);
    check("mis_valid", 32'(bus.valid_o), 32'h0);
    check("mis_pc",    bus.pc_o, 32'h202);
    rpc = 32'h0;
    step(); step();
    check("halt_fault", 32'(bus.fault_o), 32'h1);
    check("halt_pc",    bus.pc_o, 32'h202);
    check("halt_valid", 32'(bus.valid_o), 32'h0);
    redirect = 1'b0; rst = 1'b0;
    step();
    check("clr_fault", 32'(bus.fault_o), 32'h0);
    rst = 1'b1;
    step(); step();
    check("restart_pc",    bus.pc_o, RST_PC);
    check("restart_valid", 32'(bus.valid_o), 32'h1);

    // Reset during a stall together with a redirect
    ready = 1'b0;
    step();
    rst = 1'b0; redirect = 1'b1; rpc = 32'h40;
    step();
    check("rstst_valid", 32'(bus.valid_o), 32'h0);
    check("rstst_instr", bus.instr_o, NOP);
    check("rstst_cnt",   bus.fetch_cnt_o, 32'h0);
    check("rstst_addr",  32'(bus.imem_addr_o), 32'h0);
    rst = 1'b1; redirect = 1'b0;
    step(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
